my_half_adder: RTL and testbench

Single-bit-per-lane half adder with a registered shadow copy of its result and an optional carry-event counter. The combinational sum/carry path is the primitive building block for the team's adder chains; the clocked side gives downstream logic a glitch-free, cycle-aligned copy. With default parameters it behaves exactly as a one-bit half adder on its first four ports.

---
 rtl/my_half_adder_pkg.sv | 24 ++
 rtl/my_half_adder_if.sv | 36 +++
 rtl/half_adder_bit.sv | 20 ++
 rtl/my_half_adder.sv | 78 +++++++
 tb/tb_my_half_adder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/my_half_adder_pkg.sv
// ============================================================================
// Module  : my_half_adder_pkg
// Brief   : Shared constants, counter type and saturating-increment helper
//           for the my_half_adder block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package my_half_adder_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 8;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Operates on a 32-bit container so any counter width up to 32 can share it.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_val);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/my_half_adder_if.sv
// ============================================================================
// Module  : my_half_adder_if
// Brief   : Bundle of the lane operands and results of my_half_adder, with
//           master (operand driver) and slave (adder) views.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface my_half_adder_if
    import my_half_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a, b,
        input  sum, carry, sum_q, carry_q, carry_cnt
    );

    modport slave (
        input  a, b,
        output sum, carry, sum_q, carry_q, carry_cnt
    );

endinterface

`default_nettype wire

// File: rtl/half_adder_bit.sv
// ============================================================================
// Module  : half_adder_bit
// Brief   : One purely combinational half-adder lane.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module half_adder_bit (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

`default_nettype wire

// File: rtl/my_half_adder.sv
// ============================================================================
// Module  : my_half_adder
// Brief   : WIDTH independent half-adder lanes with a registered shadow copy
//           and an optional saturating carry-event counter, compiled in only
//           when MY_HALF_ADDER_STATS_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module my_half_adder
    import my_half_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
)(
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH-1:0] r_sum_q;
    logic [WIDTH-1:0] r_carry_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        half_adder_bit u_bit (
            .sum   (sum[gi]),
            .carry (carry[gi]),
            .a     (a[gi]),
            .b     (b[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q   <= '0;
            r_carry_q <= '0;
        end else begin
            r_sum_q   <= sum;
            r_carry_q <= carry;
        end
    end

    assign sum_q   = r_sum_q;
    assign carry_q = r_carry_q;

`ifdef MY_HALF_ADDER_STATS_EN
    if (1) begin : g_stats
        localparam logic [31:0] c_cnt_max = 32'((64'd1 << CNT_W) - 64'd1);

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;

        assign w_cnt_next = CNT_W'(sat_inc(32'(r_cnt), c_cnt_max));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (|carry) begin
                r_cnt <= w_cnt_next;
            end
        end

        assign carry_cnt = r_cnt;
    end
`else
    // Port kept so the instantiation footprint is identical in both builds.
    assign carry_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_my_half_adder.sv
// ============================================================================
// Module  : tb_my_half_adder
// Brief   : Self-checking bench for my_half_adder (1-lane and 4-lane copies).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_my_half_adder;
    import my_half_adder_pkg::*;

    logic clk;
    logic clk_en;
    logic rst;

    my_half_adder_if #(.WIDTH(1), .CNT_W(2)) if1 ();
    my_half_adder_if #(.WIDTH(4), .CNT_W(8)) if4 ();

    my_half_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .sum       (if1.sum),
        .carry     (if1.carry),
        .a         (if1.a),
        .b         (if1.b),
        .clk       (clk),
        .rst       (rst),
        .sum_q     (if1.sum_q),
        .carry_q   (if1.carry_q),
        .carry_cnt (if1.carry_cnt)
    );

    my_half_adder #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .sum       (if4.sum),
        .carry     (if4.carry),
        .a         (if4.a),
        .b         (if4.b),
        .clk       (clk),
        .rst       (rst),
        .sum_q     (if4.sum_q),
        .carry_q   (if4.carry_q),
        .carry_cnt (if4.carry_cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic [3:0] carry;
    } vec_t;

    typedef struct {
        logic       s1;
        logic       c1;
        logic [1:0] cnt1;
        logic [3:0] s4;
        logic [3:0] c4;
        logic [7:0] cnt4;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] exp_cnt1 = '0;
    logic [7:0] exp_cnt4 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive operands and push the values the register stage must show after the next edge.
    task automatic apply(input logic a1, input logic b1, input logic [3:0] a4, input logic [3:0] b4);
        exp_t e;
        if1.a = a1;
        if1.b = b1;
        if4.a = a4;
        if4.b = b4;
`ifdef MY_HALF_ADDER_STATS_EN
        if ((a1 & b1) && exp_cnt1 != 2'd3) exp_cnt1 = exp_cnt1 + 2'd1;
        if ((|(a4 & b4)) && exp_cnt4 != 8'hFF) exp_cnt4 = exp_cnt4 + 8'd1;
`endif
        e.s1   = a1 ^ b1;
        e.c1   = a1 & b1;
        e.cnt1 = exp_cnt1;
        e.s4   = a4 ^ b4;
        e.c4   = a4 & b4;
        e.cnt4 = exp_cnt4;
        sb_q.push_back(e);
    endtask

    task automatic capture();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check("sum_q1",   64'(if1.sum_q),     64'(e.s1));
            check("carry_q1", 64'(if1.carry_q),   64'(e.c1));
            check("cnt1",     64'(if1.carry_cnt), 64'(e.cnt1));
            check("sum_q4",   64'(if4.sum_q),     64'(e.s4));
            check("carry_q4", 64'(if4.carry_q),   64'(e.c4));
            check("cnt4",     64'(if4.carry_cnt), 64'(e.cnt4));
        end
    endtask

    task automatic drive(input logic a1, input logic b1);
        @(negedge clk);
        apply(a1, b1, 4'($urandom), 4'($urandom));
        capture();
    endtask

    initial begin
        vec_t v1[4];
        vec_t v4[4];

        v1[0] = '{4'h0, 4'h0, 4'h0, 4'h0};
        v1[1] = '{4'h0, 4'h1, 4'h1, 4'h0};
        v1[2] = '{4'h1, 4'h0, 4'h1, 4'h0};
        v1[3] = '{4'h1, 4'h1, 4'h0, 4'h1};
        v4[0] = '{4'b1100, 4'b1010, 4'b0110, 4'b1000};
        v4[1] = '{4'b1111, 4'b0101, 4'b1010, 4'b0101};
        v4[2] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000};
        v4[3] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};

        clk    = 1'b0;
        clk_en = 1'b0;
        rst    = 1'b1;
        if1.a  = '0;
        if1.b  = '0;
        if4.a  = '0;
        if4.b  = '0;
        #1;
        check("rst_sum_q",   64'(if1.sum_q),     64'd0);
        check("rst_carry_q", 64'(if1.carry_q),   64'd0);
        check("rst_cnt",     64'(if1.carry_cnt), 64'd0);

        // Combinational lanes, no clock running.
        for (int i = 0; i < 4; i++) begin
            if1.a = v1[i].a[0];
            if1.b = v1[i].b[0];
            if4.a = v4[i].a;
            if4.b = v4[i].b;
            #20;
            check($sformatf("comb1_sum[%0d]", i),   64'(if1.sum),   64'(v1[i].sum[0]));
            check($sformatf("comb1_carry[%0d]", i), 64'(if1.carry), 64'(v1[i].carry[0]));
            check($sformatf("comb4_sum[%0d]", i),   64'(if4.sum),   64'(v4[i].sum));
            check($sformatf("comb4_carry[%0d]", i), 64'(if4.carry), 64'(v4[i].carry));
        end

        if1.a = '0; if1.b = '0; if4.a = '0; if4.b = '0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_carry_q", 64'(if1.carry_q), 64'd0);

        // Release reset, then a=b=1 ahead of the first capture edge.
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 1'b1, 4'b1100, 4'b1010);
        #1;
        check("pre_edge_sum_q",   64'(if1.sum_q),   64'd0);
        check("pre_edge_carry_q", 64'(if1.carry_q), 64'd0);
        capture();

        // Four more carry cycles drive the 2-bit counter into saturation.
        repeat (4) drive(1'b1, 1'b1);
        repeat (2) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);

        // Async reset pulse between edges with carry_q set.
        drive(1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_carry_q", 64'(if1.carry_q),   64'd0);
        check("async_sum_q",   64'(if1.sum_q),     64'd0);
        check("async_cnt",     64'(if1.carry_cnt), 64'd0);
        check("async_comb",    64'(if1.carry),     64'd1);
        exp_cnt1 = '0;
        exp_cnt4 = '0;
        @(posedge clk);
        #1;
        check("rst_high_carry_q", 64'(if1.carry_q),   64'd0);
        check("rst_high_cnt",     64'(if1.carry_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
